// File: rtl/bcd_timer_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_timer_ctrl
//
// Run/pause/clear controller and sequencer for a four-digit MM:SS BCD timer.
// A prescaler divides the system clock down to one timer tick. On each tick
// the seconds-units digit advances. Every digit steps on its predecessor's
// terminal count, and all carries resolve in the same clock edge. There are
// no ripple clocks: everything runs on the rising edge of `clock`.
//
// Optional feature (compile-time macro LAP_EN):
//   When defined, a lap edge while running freezes the displayed digits and
//   sets lap_hold. The next lap edge releases the display. The live count
//   keeps running while the display is frozen. When undefined, the lap input
//   is ignored, the bcd_* outputs show the live digits and lap_hold stays 0.
//
// Parameters
//   TICK_DIV  clock cycles per timer tick (>= 2)
//   M1_MAX    terminal value of the tens-of-minutes digit (1..9)
//
// Ports
//   clock       in   system clock
//   reset_n     in   asynchronous active-low reset
//   start_stop  in   debounced level; a rising edge toggles start/pause
//   clear       in   debounced level; a rising edge requests clear
//   lap         in   debounced level; a rising edge toggles lap hold
//   bcd_s0      out  displayed seconds units  (0..9)
//   bcd_s1      out  displayed seconds tens   (0..5)
//   bcd_m0      out  displayed minutes units  (0..9)
//   bcd_m1      out  displayed minutes tens   (0..M1_MAX)
//   running     out  1 while the controller is in RUN
//   rollover    out  one-cycle pulse when the count wraps to 00:00
//   lap_hold    out  1 while the display is frozen
// ---------------------------------------------------------------------------
module bcd_timer_ctrl #(
    parameter int TICK_DIV = 50_000_000,
    parameter int M1_MAX   = 5
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] bcd_s0,
    output logic [3:0] bcd_s1,
    output logic [3:0] bcd_m0,
    output logic [3:0] bcd_m1,
    output logic       running,
    output logic       rollover,
    output logic       lap_hold
);

    localparam int         PW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0] M1_LAST = 4'(M1_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Button edge detection: one registered copy per level input. The strobe
    // is high for the single cycle between the level rising and the next edge,
    // so a held button acts only once.
    logic ss_q, clr_q;
    logic ss_rise, clr_rise;

    assign ss_rise  = start_stop & ~ss_q;
    assign clr_rise = clear & ~clr_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ss_q  <= 1'b0;
            clr_q <= 1'b0;
        end else begin
            ss_q  <= start_stop;
            clr_q <= clear;
        end
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // do_clear marks the PAUSE -> IDLE transition. A clear edge in IDLE is a
    // no-op because everything is already zero there. A clear edge in RUN is
    // deliberately ignored, so a running count cannot be wiped by accident.
    logic do_clear;

    always_comb begin
        state_nxt = state;
        do_clear  = 1'b0;
        case (state)
            IDLE: begin
                if (ss_rise) state_nxt = RUN;
            end
            RUN: begin
                if (ss_rise) state_nxt = PAUSE;
            end
            PAUSE: begin
                if (clr_rise) begin
                    state_nxt = IDLE;
                    do_clear  = 1'b1;
                end else if (ss_rise) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign running = (state == RUN);

    // Prescaler: it advances only in RUN. It holds in PAUSE, so a partial tick
    // survives a pause/resume. It is forced to zero in IDLE, so the first
    // increment lands a full TICK_DIV cycles after entering RUN.
    logic [PW-1:0] presc_q;
    logic          tick;

    assign tick = (state == RUN) && (presc_q == P_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
        end else if (state == IDLE || do_clear) begin
            presc_q <= '0;
        end else if (state == RUN) begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
        end
    end

    // Live BCD digits. The terminal checks use >= so that a corrupted digit
    // falls back to 0 instead of walking through non-BCD codes.
    logic [3:0] s0_q, s1_q, m0_q, m1_q;
    logic [3:0] s0_n, s1_n, m0_n, m1_n;
    logic       s0_max, s1_max, m0_max, m1_max;
    logic       wrap;

    assign s0_max = (s0_q >= 4'd9);
    assign s1_max = (s1_q >= 4'd5);
    assign m0_max = (m0_q >= 4'd9);
    assign m1_max = (m1_q >= M1_LAST);
    assign wrap   = tick & s0_max & s1_max & m0_max & m1_max;

    always_comb begin
        s0_n = s0_q;
        s1_n = s1_q;
        m0_n = m0_q;
        m1_n = m1_q;
        if (do_clear) begin
            s0_n = 4'd0;
            s1_n = 4'd0;
            m0_n = 4'd0;
            m1_n = 4'd0;
        end else if (tick) begin
            // All carries chain here, so the whole count moves in one edge
            s0_n = s0_max ? 4'd0 : s0_q + 4'd1;
            if (s0_max) begin
                s1_n = s1_max ? 4'd0 : s1_q + 4'd1;
                if (s1_max) begin
                    m0_n = m0_max ? 4'd0 : m0_q + 4'd1;
                    if (m0_max) begin
                        m1_n = m1_max ? 4'd0 : m1_q + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s0_q     <= 4'd0;
            s1_q     <= 4'd0;
            m0_q     <= 4'd0;
            m1_q     <= 4'd0;
            rollover <= 1'b0;
        end else begin
            s0_q     <= s0_n;
            s1_q     <= s1_n;
            m0_q     <= m0_n;
            m1_q     <= m1_n;
            rollover <= wrap;
        end
    end

`ifdef LAP_EN
    // Lap hold. Freezing is only armed while running. A release is accepted
    // in any state, so a frozen display can never get stuck.
    logic       lap_q;
    logic       lap_rise;
    logic       hold_q;
    logic [3:0] d_s0_q, d_s1_q, d_m0_q, d_m1_q;

    assign lap_rise = lap & ~lap_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lap_q  <= 1'b0;
            hold_q <= 1'b0;
            d_s0_q <= 4'd0;
            d_s1_q <= 4'd0;
            d_m0_q <= 4'd0;
            d_m1_q <= 4'd0;
        end else begin
            lap_q <= lap;
            if (do_clear) begin
                hold_q <= 1'b0;
            end else if (lap_rise) begin
                if (hold_q) begin
                    hold_q <= 1'b0;
                end else if (state == RUN) begin
                    hold_q <= 1'b1;
                    d_s0_q <= s0_q;
                    d_s1_q <= s1_q;
                    d_m0_q <= m0_q;
                    d_m1_q <= m1_q;
                end
            end
        end
    end

    assign bcd_s0   = hold_q ? d_s0_q : s0_q;
    assign bcd_s1   = hold_q ? d_s1_q : s1_q;
    assign bcd_m0   = hold_q ? d_m0_q : m0_q;
    assign bcd_m1   = hold_q ? d_m1_q : m1_q;
    assign lap_hold = hold_q;
`else
    // The lap input stays on the port list so both builds share one pinout
    logic unused_lap;
    assign unused_lap = lap;

    assign bcd_s0   = s0_q;
    assign bcd_s1   = s1_q;
    assign bcd_m0   = m0_q;
    assign bcd_m1   = m1_q;
    assign lap_hold = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Testbench for bcd_timer_ctrl with TICK_DIV=4 and M1_MAX=5.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_bcd_timer_ctrl;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic       lap = 1'b0;
    logic [3:0] bcd_s0, bcd_s1, bcd_m0, bcd_m1;
    logic       running, rollover, lap_hold;
    logic [15:0] view;

    int errors = 0;
    int checks = 0;

    assign view = {bcd_m1, bcd_m0, bcd_s1, bcd_s0};

    bcd_timer_ctrl #(.TICK_DIV(4), .M1_MAX(5)) dut (
        .clock(clock), .reset_n(reset_n), .start_stop(start_stop),
        .clear(clear), .lap(lap),
        .bcd_s0(bcd_s0), .bcd_s1(bcd_s1), .bcd_m0(bcd_m0), .bcd_m1(bcd_m1),
        .running(running), .rollover(rollover), .lap_hold(lap_hold)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Button pulse: it rises on one falling edge and drops on the next, so
    // exactly one rising clock edge sees the strobe. On return, that edge has
    // already happened.
    task automatic press_ss();
        start_stop = 1'b1;
        cyc(1);
        start_stop = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
    endtask

    task automatic test_reset();
        start_stop = 0; clear = 0; lap = 0;
        cyc(1);
        do_reset();
        checks++; if (view !== 16'h0000) begin errors++; $display("FAIL reset_digits: got %h want 0000", view); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running); end
        checks++; if (rollover !== 1'b0) begin errors++; $display("FAIL reset_rollover: got %b want 0", rollover); end
        checks++; if (lap_hold !== 1'b0) begin errors++; $display("FAIL reset_lap_hold: got %b want 0", lap_hold); end
    endtask

    task automatic test_start();
        int bad_run;
        press_ss();
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL start_running: got %b want 1", running); end
        for (int k = 1; k <= 3; k++) begin
            cyc(1);
            checks++; if (view !== 16'h0000) begin errors++; $display("FAIL start_early_%0d: got %h want 0000", k, view); end
        end
        cyc(1);
        checks++; if (view !== 16'h0001) begin errors++; $display("FAIL start_first_tick: got %h want 0001", view); end
        bad_run = 0;
        for (int i = 0; i < 156; i++) begin
            cyc(1);
            if (running !== 1'b1) bad_run++;
        end
        checks++; if (view !== 16'h0040) begin errors++; $display("FAIL start_40_ticks: got %h want 0040", view); end
        checks++; if (bad_run !== 0) begin errors++; $display("FAIL start_running_held: got %0d drops want 0", bad_run); end
    endtask

    // Entered right after a tick edge, with the display at 00:40
    task automatic test_pause_resume();
        int changed;
        cyc(1);
        press_ss();
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL pause_running: got %b want 0", running); end
        changed = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (view !== 16'h0040) changed++;
        end
        checks++; if (changed !== 0) begin errors++; $display("FAIL pause_frozen: got %0d changes want 0", changed); end
        press_ss();
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL resume_running: got %b want 1", running); end
        checks++; if (view !== 16'h0040) begin errors++; $display("FAIL resume_edge: got %h want 0040", view); end
        cyc(1);
        checks++; if (view !== 16'h0040) begin errors++; $display("FAIL resume_plus1: got %h want 0040", view); end
        cyc(1);
        checks++; if (view !== 16'h0041) begin errors++; $display("FAIL resume_plus2: got %h want 0041", view); end
    endtask

    // Entered right after a tick edge, with the display at 00:41
    task automatic test_clear();
        int moved;
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL clear_in_run_state: got %b want 1", running); end
        checks++; if (view !== 16'h0041) begin errors++; $display("FAIL clear_in_run_digits: got %h want 0041", view); end
        cyc(3);
        checks++; if (view !== 16'h0042) begin errors++; $display("FAIL clear_in_run_tick: got %h want 0042", view); end
        press_ss();
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL clear_pause: got %b want 0", running); end
        cyc(2);
        clear = 1'b1;
        start_stop = 1'b1;
        cyc(1);
        clear = 1'b0;
        start_stop = 1'b0;
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL clear_wins_running: got %b want 0", running); end
        checks++; if (view !== 16'h0000) begin errors++; $display("FAIL clear_wins_digits: got %h want 0000", view); end
        moved = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if (view !== 16'h0000 || running !== 1'b0) moved++;
        end
        checks++; if (moved !== 0) begin errors++; $display("FAIL clear_idle_stays: got %0d changes want 0", moved); end
        press_ss();
        cyc(3);
        checks++; if (view !== 16'h0000) begin errors++; $display("FAIL clear_restart_early: got %h want 0000", view); end
        cyc(1);
        checks++; if (view !== 16'h0001) begin errors++; $display("FAIL clear_restart_tick: got %h want 0001", view); end
    endtask

    task automatic test_async_reset();
        int moved;
        do_reset();
        press_ss();
        cyc(754 * 4);
        checks++; if (view !== 16'h1234) begin errors++; $display("FAIL areset_reach: got %h want 1234", view); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (view !== 16'h0000) begin errors++; $display("FAIL areset_digits: got %h want 0000", view); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL areset_running: got %b want 0", running); end
        cyc(2);
        reset_n = 1'b1;
        moved = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if (view !== 16'h0000 || running !== 1'b0 || rollover !== 1'b0) moved++;
        end
        checks++; if (moved !== 0) begin errors++; $display("FAIL areset_idle_after: got %0d changes want 0", moved); end
    endtask

    task automatic test_rollover();
        int early;
        do_reset();
        press_ss();
        early = 0;
        for (int i = 0; i < 3599 * 4; i++) begin
            cyc(1);
            if (rollover !== 1'b0) early++;
        end
        checks++; if (view !== 16'h5959) begin errors++; $display("FAIL roll_reach: got %h want 5959", view); end
        checks++; if (early !== 0) begin errors++; $display("FAIL roll_early_pulse: got %0d pulses want 0", early); end
        cyc(4);
        checks++; if (view !== 16'h0000) begin errors++; $display("FAIL roll_wrap_digits: got %h want 0000", view); end
        checks++; if (rollover !== 1'b1) begin errors++; $display("FAIL roll_pulse: got %b want 1", rollover); end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL roll_running: got %b want 1", running); end
        cyc(1);
        checks++; if (rollover !== 1'b0) begin errors++; $display("FAIL roll_pulse_width: got %b want 0", rollover); end
        cyc(3);
        checks++; if (view !== 16'h0001) begin errors++; $display("FAIL roll_continue: got %h want 0001", view); end
    endtask

    task automatic test_lap();
        do_reset();
        press_ss();
        cyc(7 * 4);
        checks++; if (view !== 16'h0007) begin errors++; $display("FAIL lap_reach7: got %h want 0007", view); end
        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
`ifdef LAP_EN
        checks++; if (lap_hold !== 1'b1) begin errors++; $display("FAIL lap_set: got %b want 1", lap_hold); end
`else
        checks++; if (lap_hold !== 1'b0) begin errors++; $display("FAIL lap_ignored: got %b want 0", lap_hold); end
`endif
        checks++; if (view !== 16'h0007) begin errors++; $display("FAIL lap_view7: got %h want 0007", view); end
        cyc(31);
`ifdef LAP_EN
        checks++; if (view !== 16'h0007) begin errors++; $display("FAIL lap_frozen: got %h want 0007", view); end
        checks++; if (lap_hold !== 1'b1) begin errors++; $display("FAIL lap_held: got %b want 1", lap_hold); end
`else
        checks++; if (view !== 16'h0015) begin errors++; $display("FAIL lap_live15: got %h want 0015", view); end
        checks++; if (lap_hold !== 1'b0) begin errors++; $display("FAIL lap_still_zero: got %b want 0", lap_hold); end
`endif
        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
        checks++; if (view !== 16'h0015) begin errors++; $display("FAIL lap_release_view: got %h want 0015", view); end
        checks++; if (lap_hold !== 1'b0) begin errors++; $display("FAIL lap_release_hold: got %b want 0", lap_hold); end
        cyc(3);
        checks++; if (view !== 16'h0016) begin errors++; $display("FAIL lap_live_after: got %h want 0016", view); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_pause_resume();
        test_clear();
        test_async_reset();
        test_rollover();
        test_lap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
